// File: rtl/wires_4x4b_to_5x3b_unpack.sv
// Receive-side unpacker: gathers four 4-bit nibbles into a 16-bit word {marker, in4..in0}
// and presents the five 3-bit fields on a registered valid/ready output stage.
module wires_4x4b_to_5x3b_unpack #(
   parameter bit CHECK_MARKER = 1'b1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       sync,
   input  logic       in_val,
   output logic       in_rdy,
   input  logic [3:0] in_nibble,
   output logic       out_val,
   input  logic       out_rdy,
   output logic [2:0] out0,
   output logic [2:0] out1,
   output logic [2:0] out2,
   output logic [2:0] out3,
   output logic [2:0] out4,
   output logic       out_err
);

   logic [1:0]  cnt;
   logic [11:0] partial;
   logic [15:0] word;
   logic        nib_xfer;
   logic        word_xfer;
   logic        complete;

   // Only the completing nibble can stall, and only behind a full output stage that is not draining.
   // NOTE: every signal driven in always_comb gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      in_rdy    = 1'b1;
      nib_xfer  = 1'b0;
      word_xfer = 1'b0;
      complete  = 1'b0;
      word      = {in_nibble, partial};
      if (cnt == 2'd3 && out_val && !out_rdy) begin
         in_rdy = 1'b0;
      end
      nib_xfer  = in_val && in_rdy && !sync;
      word_xfer = out_val && out_rdy;
      complete  = nib_xfer && (cnt == 2'd3);
   end

   // Assembly stage; sync discards the partial word and any nibble offered alongside it.
   // NOTE: the partial buffer is a handful of flops, not a memory, so it is reset like any other state.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt     <= 2'd0;
         partial <= 12'd0;
      end else if (sync) begin
         cnt     <= 2'd0;
         partial <= 12'd0;
      end else if (nib_xfer) begin
         case (cnt)
            2'd0:    partial[3:0]  <= in_nibble;
            2'd1:    partial[7:4]  <= in_nibble;
            2'd2:    partial[11:8] <= in_nibble;
            default: ;
         endcase
         cnt <= cnt + 2'd1;
      end
   end

   // Output stage: fields hold while presented; a simultaneous drain and completion keeps out_val high.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_val <= 1'b0;
         out_err <= 1'b0;
         out0    <= 3'd0;
         out1    <= 3'd0;
         out2    <= 3'd0;
         out3    <= 3'd0;
         out4    <= 3'd0;
      end else if (complete) begin
         out_val <= 1'b1;
         out_err <= CHECK_MARKER & ~in_nibble[3];
         out0    <= word[2:0];
         out1    <= word[5:3];
         out2    <= word[8:6];
         out3    <= word[11:9];
         out4    <= word[14:12];
      end else if (word_xfer) begin
         out_val <= 1'b0;
      end
   end

endmodule

// File: tb/tb_wires_4x4b_to_5x3b_unpack.sv
// Bench for the nibble unpacker: directed scenarios plus random traffic against a queue-based word model.
module tb_wires_4x4b_to_5x3b_unpack;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       sync = 1'b0;
   logic       in_val = 1'b0;
   logic [3:0] in_nibble = 4'd0;
   logic       out_rdy = 1'b0;
   logic       in_rdy, out_val, out_err;
   logic [2:0] out0, out1, out2, out3, out4;
   logic       nm_rdy, nm_val, nm_err;
   logic [2:0] nm0, nm1, nm2, nm3, nm4;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state: nibbles gathered so far, and the word presented at the output.
   logic [3:0]  part[$];
   logic        m_val = 1'b0;
   logic [14:0] m_fields = 15'd0;
   logic        m_err = 1'b0;

   always #5 clk = ~clk;

   wires_4x4b_to_5x3b_unpack dut (
      .clk(clk), .reset_n(reset_n), .sync(sync), .in_val(in_val), .in_rdy(in_rdy),
      .in_nibble(in_nibble), .out_val(out_val), .out_rdy(out_rdy),
      .out0(out0), .out1(out1), .out2(out2), .out3(out3), .out4(out4), .out_err(out_err)
   );

   wires_4x4b_to_5x3b_unpack #(.CHECK_MARKER(1'b0)) dut_nm (
      .clk(clk), .reset_n(reset_n), .sync(sync), .in_val(in_val), .in_rdy(nm_rdy),
      .in_nibble(in_nibble), .out_val(nm_val), .out_rdy(out_rdy),
      .out0(nm0), .out1(nm1), .out2(nm2), .out3(nm3), .out4(nm4), .out_err(nm_err)
   );

   function automatic logic [6:0] e(input logic v, input logic [3:0] n, input logic r, input logic s);
      return {v, r, s, n};
   endfunction

   task automatic model_reset();
      part.delete();
      m_val    = 1'b0;
      m_fields = 15'd0;
      m_err    = 1'b0;
   endtask

   // One clock: drive at the falling edge, advance the model, observe after the rising edge.
   task automatic step(input logic [6:0] ent, output logic [36:0] obs, output logic [36:0] expv);
      logic v, r, s, rdy_m, rdy_a, rdy_b, done;
      logic [3:0]  n;
      logic [15:0] w;
      {v, r, s, n} = ent;
      @(negedge clk);
      in_val = v; in_nibble = n; out_rdy = r; sync = s;
      #1;
      rdy_a = in_rdy;
      rdy_b = nm_rdy;
      rdy_m = !(part.size() == 3 && m_val && !r);
      done  = 1'b0;
      if (s) begin
         part.delete();
      end else if (v && rdy_m) begin
         part.push_back(n);
         if (part.size() == 4) begin
            w = {part[3], part[2], part[1], part[0]};
            m_fields = w[14:0];
            m_err    = ~w[15];
            m_val    = 1'b1;
            done     = 1'b1;
            part.delete();
         end
      end
      if (!done && m_val && r) m_val = 1'b0;
      @(posedge clk);
      #1;
      obs  = {rdy_a, out_val, out4, out3, out2, out1, out0, out_err,
              rdy_b, nm_val, nm4, nm3, nm2, nm1, nm0, nm_err};
      expv = {rdy_m, m_val, m_fields, m_err, rdy_m, m_val, m_fields, 1'b0};
   endtask

   task automatic test_reset();
      logic [36:0] obs, expv;
      reset_n = 1'b0;
      model_reset();
      #12;
      obs  = {in_rdy, out_val, out4, out3, out2, out1, out0, out_err,
              nm_rdy, nm_val, nm4, nm3, nm2, nm1, nm0, nm_err};
      expv = {2'b11, 16'd0, 2'b11, 16'd0} & 37'h1F_FFFF_FFFF;
      expv = {1'b1, 1'b0, 15'd0, 1'b0, 1'b1, 1'b0, 15'd0, 1'b0};
      n_cmp++;
      if (obs !== expv) begin
         n_bad++;
         $display("FAIL reset: got %h want %h", obs, expv);
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_nominal();
      logic [6:0]  t[$];
      logic [36:0] obs, expv;
      t = '{e(1,4'h1,1,0), e(1,4'hD,1,0), e(1,4'h8,1,0), e(1,4'hD,1,0), e(0,4'h0,1,0), e(0,4'h0,1,0)};
      foreach (t[i]) begin
         step(t[i], obs, expv);
         n_cmp++;
         if (obs !== expv) begin
            n_bad++;
            $display("FAIL nominal[%0d]: got %h want %h", i, obs, expv);
         end
      end
   endtask

   task automatic test_extremes_marker();
      logic [6:0]  t[$];
      logic [36:0] obs, expv;
      t = '{e(1,4'hF,1,0), e(1,4'hF,1,0), e(1,4'hF,1,0), e(1,4'hF,1,0),
            e(1,4'h0,1,0), e(1,4'h0,1,0), e(1,4'h0,1,0), e(1,4'h8,1,0),
            e(1,4'h0,1,0), e(1,4'h0,1,0), e(1,4'h0,1,0), e(1,4'h0,0,0),
            e(0,4'h0,0,0), e(0,4'h0,1,0), e(0,4'h0,1,0)};
      foreach (t[i]) begin
         step(t[i], obs, expv);
         n_cmp++;
         if (obs !== expv) begin
            n_bad++;
            $display("FAIL extremes_marker[%0d]: got %h want %h", i, obs, expv);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [6:0]  t[$];
      logic [36:0] obs, expv;
      t = '{e(1,4'h1,1,0), e(1,4'hD,1,0), e(1,4'h8,1,0), e(1,4'hD,1,0),
            e(1,4'hF,0,0), e(1,4'hF,0,0), e(1,4'hF,0,0), e(1,4'hF,0,0), e(1,4'hF,0,0),
            e(1,4'hF,1,0), e(0,4'h0,0,0), e(0,4'h0,1,0), e(0,4'h0,1,0)};
      foreach (t[i]) begin
         step(t[i], obs, expv);
         n_cmp++;
         if (obs !== expv) begin
            n_bad++;
            $display("FAIL backpressure[%0d]: got %h want %h", i, obs, expv);
         end
      end
   endtask

   task automatic test_resync();
      logic [6:0]  t[$];
      logic [36:0] obs, expv;
      t = '{e(1,4'h1,1,0), e(1,4'hD,1,0), e(1,4'h8,1,1),
            e(1,4'h1,1,0), e(1,4'hD,1,0), e(1,4'h8,1,0), e(1,4'hD,1,0),
            e(0,4'h0,1,0), e(0,4'h0,1,0)};
      foreach (t[i]) begin
         step(t[i], obs, expv);
         n_cmp++;
         if (obs !== expv) begin
            n_bad++;
            $display("FAIL resync[%0d]: got %h want %h", i, obs, expv);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [6:0]  t[$];
      logic [36:0] obs, expv;
      // Held word 0x58D1 carries a marker error and non-zero fields, then two nibbles of the next word.
      t = '{e(1,4'h1,0,0), e(1,4'hD,0,0), e(1,4'h8,0,0), e(1,4'h5,0,0), e(1,4'h3,0,0), e(1,4'h6,0,0)};
      foreach (t[i]) begin
         step(t[i], obs, expv);
         n_cmp++;
         if (obs !== expv) begin
            n_bad++;
            $display("FAIL reset_mid_load[%0d]: got %h want %h", i, obs, expv);
         end
      end
      @(negedge clk);
      in_val = 1'b0;
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      obs  = {in_rdy, out_val, out4, out3, out2, out1, out0, out_err,
              nm_rdy, nm_val, nm4, nm3, nm2, nm1, nm0, nm_err};
      expv = {1'b1, 1'b0, 15'd0, 1'b0, 1'b1, 1'b0, 15'd0, 1'b0};
      n_cmp++;
      if (obs !== expv) begin
         n_bad++;
         $display("FAIL reset_mid_async: got %h want %h", obs, expv);
      end
      @(negedge clk);
      reset_n = 1'b1;
      t = '{e(0,4'h0,1,0), e(1,4'h1,1,0), e(1,4'hD,1,0), e(1,4'h8,1,0), e(1,4'hD,1,0), e(0,4'h0,1,0)};
      foreach (t[i]) begin
         step(t[i], obs, expv);
         n_cmp++;
         if (obs !== expv) begin
            n_bad++;
            $display("FAIL reset_mid_after[%0d]: got %h want %h", i, obs, expv);
         end
      end
   endtask

   task automatic test_random();
      logic [36:0] obs, expv;
      logic [6:0]  ent;
      for (int i = 0; i < 600; i++) begin
         ent = e(($urandom % 4) != 0, 4'($urandom), ($urandom % 3) != 0, ($urandom % 25) == 0);
         step(ent, obs, expv);
         n_cmp++;
         if (obs !== expv) begin
            n_bad++;
            $display("FAIL random[%0d]: got %h want %h", i, obs, expv);
         end
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_extremes_marker();
      test_backpressure();
      test_resync();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
